// File: rtl/expr_eval.sv
// Streaming evaluator for digit/'+'/'*' expressions terminated by '='.
// '*' binds tighter than '+'; all arithmetic wraps modulo 2^W.
module expr_eval #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         in_valid,
    input  logic [7:0]   in,
    output logic         ok,
    output logic [W-1:0] value,
    output logic         done,
    output logic         done_ok,
    output logic [W-1:0] result
);

    typedef enum logic [1:0] {
        ST_START   = 2'd0,
        ST_EXP_OPR = 2'd1,
        ST_EXP_DIG = 2'd2,
        ST_ERR     = 2'd3
    } state_e;

    localparam logic [7:0] CH_ZERO = 8'h30;
    localparam logic [7:0] CH_NINE = 8'h39;
    localparam logic [7:0] CH_ADD  = 8'h2B;
    localparam logic [7:0] CH_MUL  = 8'h2A;
    localparam logic [7:0] CH_EQ   = 8'h3D;

    state_e         state_q, state_d;
    logic [W-1:0]   sum_q, sum_d;
    logic [W-1:0]   term_q, term_d;
    logic           mul_q, mul_d;      // pending operator: 1 = '*', 0 = '+'
    logic           ok_q, ok_d;
    logic [W-1:0]   value_q, value_d;
    logic           done_q, done_d;
    logic           done_ok_q, done_ok_d;
    logic [W-1:0]   result_q, result_d;

    logic           is_digit;
    logic           is_op;
    logic           is_eq;
    logic [W-1:0]   dig;

    // Character classification; ASCII digits carry their value in the low nibble.
    always_comb begin
        is_digit = (in >= CH_ZERO) && (in <= CH_NINE);
        is_op    = (in == CH_ADD) || (in == CH_MUL);
        is_eq    = (in == CH_EQ);
        dig      = W'(in[3:0]);
    end

    // Next-state, evaluation and output computation.
    always_comb begin
        state_d   = state_q;
        sum_d     = sum_q;
        term_d    = term_q;
        mul_d     = mul_q;
        ok_d      = ok_q;
        value_d   = value_q;
        done_d    = 1'b0;
        done_ok_d = done_ok_q;
        result_d  = result_q;

        if (in_valid) begin
            if (is_eq) begin
                state_d   = ST_START;
                done_d    = 1'b1;
                done_ok_d = (state_q == ST_EXP_OPR);
                if (state_q == ST_EXP_OPR) begin
                    result_d = value_q;
                end
                sum_d   = '0;
                term_d  = '0;
                mul_d   = 1'b0;
                value_d = '0;
            end else begin
                case (state_q)
                    ST_START: begin
                        if (is_digit) begin
                            state_d = ST_EXP_OPR;
                            sum_d   = '0;
                            term_d  = dig;
                            value_d = dig;
                        end else begin
                            state_d = ST_ERR;
                        end
                    end
                    ST_EXP_OPR: begin
                        if (is_op) begin
                            state_d = ST_EXP_DIG;
                            mul_d   = (in == CH_MUL);
                        end else begin
                            state_d = ST_ERR;
                        end
                    end
                    ST_EXP_DIG: begin
                        if (is_digit) begin
                            state_d = ST_EXP_OPR;
                            if (mul_q) begin
                                term_d = term_q * dig;
                            end else begin
                                sum_d  = sum_q + term_q;
                                term_d = dig;
                            end
                            value_d = sum_d + term_d;
                        end else begin
                            state_d = ST_ERR;
                        end
                    end
                    ST_ERR:  state_d = ST_ERR;
                    default: state_d = ST_ERR;
                endcase
            end
            ok_d = (state_d == ST_EXP_OPR);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= ST_START;
            sum_q     <= '0;
            term_q    <= '0;
            mul_q     <= 1'b0;
            ok_q      <= 1'b0;
            value_q   <= '0;
            done_q    <= 1'b0;
            done_ok_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            sum_q     <= sum_d;
            term_q    <= term_d;
            mul_q     <= mul_d;
            ok_q      <= ok_d;
            value_q   <= value_d;
            done_q    <= done_d;
            done_ok_q <= done_ok_d;
            result_q  <= result_d;
        end
    end

    assign ok      = ok_q;
    assign value   = value_q;
    assign done    = done_q;
    assign done_ok = done_ok_q;
    assign result  = result_q;

endmodule
